dso100_intr_ctrl: RTL and testbench

Interrupt source controller inside the DSO100 framebuffer peripheral. It produces the level-high `DSO100FB_INTR` line that the interrupt interconnect forwards to the PS. Internal event sources are rising-edge detected and latched into sticky status bits, then masked by an enable register. The result is presented as one registered, level-sensitive interrupt. Software services the interrupt through a small word-addressed register port using write-1-to-clear semantics.

---
 rtl/dso100_intr_pkg.sv | 12 +
 rtl/dso100_intr_edge.sv | 23 ++
 rtl/dso100_intr_ctrl.sv | 99 +++++++++
 tb/tb_dso100_intr_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dso100_intr_pkg.sv
// Shared constants for the DSO100 framebuffer interrupt controller:
// register word indices and the register data width.
package dso100_intr_pkg;

  localparam int INTR_DATA_W = 32;

  localparam logic [1:0] INTR_REG_STATUS  = 2'd0;
  localparam logic [1:0] INTR_REG_ENABLE  = 2'd1;
  localparam logic [1:0] INTR_REG_PENDING = 2'd2;
  localparam logic [1:0] INTR_REG_FORCE   = 2'd3;

endpackage

// File: rtl/dso100_intr_edge.sv
// Per-source rising-edge detector. prev clears on reset, so a source that is
// already high when reset releases produces one event.
module dso100_intr_edge
  import dso100_intr_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_event,
  output logic [NUM_SRC-1:0] rise
);

  logic [NUM_SRC-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= src_event;
  end

  assign rise = src_event & ~prev;

endmodule

// File: rtl/dso100_intr_ctrl.sv
// DSO100 framebuffer interrupt controller: sticky W1C status, enable mask and a
// registered level interrupt. Define DSO100_INTR_HOLDOFF_EN for a minimum low time.
module dso100_intr_ctrl
  import dso100_intr_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_SRC-1:0]     SRC_EVENT,
  input  logic                   REG_WE,
  input  logic                   REG_RE,
  input  logic [1:0]             REG_ADDR,
  input  logic [INTR_DATA_W-1:0] REG_WDATA,
  output logic [INTR_DATA_W-1:0] REG_RDATA,
  output logic                   DSO100FB_INTR
);

  if (NUM_SRC < 1 || NUM_SRC > 32 || HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 65535) begin : g_bad_param
    $error("dso100_intr_ctrl: parameter out of range");
  end

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] status;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] wdata_src;
  logic [NUM_SRC-1:0] w1c_wr;
  logic [NUM_SRC-1:0] force_wr;
  logic [NUM_SRC-1:0] pending;
  logic               req;
  logic               intr_next;
  logic [INTR_DATA_W-1:0] rdata_next;
  logic               unused_wdata;

  dso100_intr_edge #(.NUM_SRC(NUM_SRC)) u_edge (
    .clk       (CLK),
    .rst       (RST),
    .src_event (SRC_EVENT),
    .rise      (rise)
  );

  assign wdata_src    = REG_WDATA[NUM_SRC-1:0];
  assign unused_wdata = ^REG_WDATA;
  assign w1c_wr       = (REG_WE && REG_ADDR == INTR_REG_STATUS) ? wdata_src : '0;
  assign force_wr     = (REG_WE && REG_ADDR == INTR_REG_FORCE)  ? wdata_src : '0;
  assign pending      = status & enable;
  assign req          = |pending;

  always_comb begin
    rdata_next = '0;
    case (REG_ADDR)
      INTR_REG_STATUS:  rdata_next = INTR_DATA_W'(status);
      INTR_REG_ENABLE:  rdata_next = INTR_DATA_W'(enable);
      INTR_REG_PENDING: rdata_next = INTR_DATA_W'(pending);
      default:          rdata_next = '0;
    endcase
  end

  // Set after clear: an event coinciding with its own W1C is kept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      status    <= '0;
      enable    <= '0;
      REG_RDATA <= '0;
    end else begin
      status <= (status & ~w1c_wr) | rise | force_wr;
      if (REG_WE && REG_ADDR == INTR_REG_ENABLE) enable <= wdata_src;
      if (REG_RE) REG_RDATA <= rdata_next;
    end
  end

`ifdef DSO100_INTR_HOLDOFF_EN
  logic [15:0] holdoff_cnt;
  logic        holdoff_open;

  // Opening on the final count gives exactly HOLDOFF_CYCLES low cycles.
  assign holdoff_open = (holdoff_cnt <= 16'd1);
  assign intr_next    = req & holdoff_open;

  always_ff @(posedge CLK) begin
    if (RST) begin
      holdoff_cnt <= '0;
    end else if (DSO100FB_INTR && !intr_next) begin
      holdoff_cnt <= 16'(HOLDOFF_CYCLES);
    end else if (holdoff_cnt != 16'd0) begin
      holdoff_cnt <= holdoff_cnt - 16'd1;
    end
  end
`else
  assign intr_next = req;
`endif

  always_ff @(posedge CLK) begin
    if (RST) DSO100FB_INTR <= 1'b0;
    else     DSO100FB_INTR <= intr_next;
  end

endmodule

// File: tb/tb_dso100_intr_ctrl.sv
// Directed self-checking bench for dso100_intr_ctrl (NUM_SRC=4, HOLDOFF_CYCLES=16).
module tb_dso100_intr_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  SRC_EVENT = '0;
  logic        REG_WE = 1'b0;
  logic        REG_RE = 1'b0;
  logic [1:0]  REG_ADDR = '0;
  logic [31:0] REG_WDATA = '0;
  logic [31:0] REG_RDATA;
  logic        DSO100FB_INTR;

  int n_chk = 0;
  int n_err = 0;

  dso100_intr_ctrl #(.NUM_SRC(4), .HOLDOFF_CYCLES(16)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .SRC_EVENT     (SRC_EVENT),
    .REG_WE        (REG_WE),
    .REG_RE        (REG_RE),
    .REG_ADDR      (REG_ADDR),
    .REG_WDATA     (REG_WDATA),
    .REG_RDATA     (REG_RDATA),
    .DSO100FB_INTR (DSO100FB_INTR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
    REG_WE = 1'b1; REG_ADDR = addr; REG_WDATA = data;
    tick();
    REG_WE = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
    REG_RE = 1'b1; REG_ADDR = addr;
    tick();
    REG_RE = 1'b0;
    data = REG_RDATA;
  endtask

  logic [31:0] rd;
  int          low_cnt;

  initial begin
    tick(); tick();
    RST = 1'b0;
    chk("rst_intr", {31'd0, DSO100FB_INTR}, 32'd0);
    chk("rst_rdata", REG_RDATA, 32'd0);
    reg_read(2'd0, rd); chk("rst_status", rd, 32'd0);
    reg_read(2'd1, rd); chk("rst_enable", rd, 32'd0);

    // basic event -> interrupt -> W1C
    reg_write(2'd1, 32'h1);
    SRC_EVENT = 4'b0001; tick(); SRC_EVENT = '0;
    chk("ev_intr_n", {31'd0, DSO100FB_INTR}, 32'd0);
    tick();
    chk("ev_intr_n1", {31'd0, DSO100FB_INTR}, 32'd1);
    reg_read(2'd0, rd); chk("ev_status", rd, 32'h1);
    reg_write(2'd0, 32'h1);
    chk("clr_intr_n", {31'd0, DSO100FB_INTR}, 32'd1);
    tick();
    chk("clr_intr_n1", {31'd0, DSO100FB_INTR}, 32'd0);

    // masked event, later enabled, then disabled
    reg_write(2'd1, 32'h0);
    SRC_EVENT = 4'b0100; tick(); SRC_EVENT = '0;
    tick(); tick();
    chk("mask_intr", {31'd0, DSO100FB_INTR}, 32'd0);
    reg_read(2'd0, rd); chk("mask_status", rd, 32'h4);
    reg_read(2'd2, rd); chk("mask_pending", rd, 32'h0);
    reg_write(2'd1, 32'h4);
    chk("en_intr_n", {31'd0, DSO100FB_INTR}, 32'd0);
    tick();
    chk("en_intr_n1", {31'd0, DSO100FB_INTR}, 32'd1);
    reg_read(2'd2, rd); chk("en_pending", rd, 32'h4);
    reg_write(2'd1, 32'h0); tick();
    chk("dis_intr", {31'd0, DSO100FB_INTR}, 32'd0);
    reg_read(2'd0, rd); chk("dis_status_kept", rd, 32'h4);
    reg_write(2'd0, 32'h4);
    reg_write(2'd1, 32'hFFFF_FFFF);
    reg_read(2'd1, rd); chk("enable_width", rd, 32'hF);

    // held source with mid-way W1C: exactly one event
    reg_write(2'd1, 32'h2);
    SRC_EVENT = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin REG_WE = 1'b1; REG_ADDR = 2'd0; REG_WDATA = 32'h2; end
      tick();
      REG_WE = 1'b0;
    end
    reg_read(2'd0, rd); chk("held_status", rd, 32'h0);
    chk("held_intr", {31'd0, DSO100FB_INTR}, 32'd0);
    SRC_EVENT = '0; tick();
    SRC_EVENT = 4'b0010; tick(); SRC_EVENT = '0;
    reg_read(2'd0, rd); chk("reedge_status", rd, 32'h2);
    reg_write(2'd0, 32'h2);

    // rise coincident with W1C of the same bit: set wins
    SRC_EVENT = 4'b1000; tick(); SRC_EVENT = '0; tick();
    SRC_EVENT = 4'b1000; REG_WE = 1'b1; REG_ADDR = 2'd0; REG_WDATA = 32'h8;
    tick();
    REG_WE = 1'b0; SRC_EVENT = '0;
    reg_read(2'd0, rd); chk("setwins_status", rd, 32'h8);
    reg_write(2'd0, 32'h8);
    reg_read(2'd0, rd); chk("w1c_status", rd, 32'h0);

    // FORCE and ignored writes
    reg_write(2'd1, 32'hF);
    reg_write(2'd3, 32'h3);
    reg_read(2'd0, rd); chk("force_status", rd, 32'h3);
    chk("force_intr", {31'd0, DSO100FB_INTR}, 32'd1);
    reg_read(2'd3, rd); chk("force_read", rd, 32'h0);
    reg_write(2'd3, 32'hFFFF_FFF0);
    reg_write(2'd2, 32'h0);
    reg_read(2'd0, rd); chk("force_upper", rd, 32'h3);
    reg_read(2'd1, rd); chk("pend_wr_ignored", rd, 32'hF);

    // simultaneous write and read returns the old value
    REG_WE = 1'b1; REG_RE = 1'b1; REG_ADDR = 2'd1; REG_WDATA = 32'h5;
    tick();
    REG_WE = 1'b0; REG_RE = 1'b0;
    chk("rw_old", REG_RDATA, 32'hF);
    reg_read(2'd1, rd); chk("rw_new", rd, 32'h5);

    // reset mid-operation drops state and the coincident event
    RST = 1'b1; SRC_EVENT = 4'b0100; tick();
    RST = 1'b0; SRC_EVENT = '0;
    chk("mid_rst_intr", {31'd0, DSO100FB_INTR}, 32'd0);
    chk("mid_rst_rdata", REG_RDATA, 32'd0);
    reg_read(2'd0, rd); chk("mid_rst_status", rd, 32'h0);
    reg_read(2'd1, rd); chk("mid_rst_enable", rd, 32'h0);

`ifdef DSO100_INTR_HOLDOFF_EN
    reg_write(2'd1, 32'h1);
    SRC_EVENT = 4'b0001; tick(); SRC_EVENT = '0; tick();
    chk("ho_intr_hi", {31'd0, DSO100FB_INTR}, 32'd1);
    reg_write(2'd0, 32'h1);
    tick();
    chk("ho_fall", {31'd0, DSO100FB_INTR}, 32'd0);
    low_cnt = 1;
    SRC_EVENT = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      tick();
      SRC_EVENT = '0;
      if (DSO100FB_INTR) break;
      low_cnt++;
    end
    chk("ho_low_cycles", low_cnt, 32'd16);
    chk("ho_rehigh", {31'd0, DSO100FB_INTR}, 32'd1);
`else
    low_cnt = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
